// File: rtl/jtag_tap_controller.sv
// rtl/jtag_tap_controller.sv - IEEE 1149.1 TAP controller with IR, BYPASS and IDCODE registers
//
// Purpose:
//   Decodes TMS into the 16-state TAP state machine and owns the instruction
//   register, the 1-bit BYPASS register and the 32-bit IDCODE register. It
//   drives the capture/shift/update strobes, BSR select and mode for the
//   boundary-scan register, and multiplexes the serial TDO.
//
// Ports:
//   TCK          in   1         sole clock, all state changes on rising edge
//   nTRST        in   1         synchronous active-low reset
//   TMS          in   1         mode select
//   TDI          in   1         serial data in
//   bsr_tdo      in   1         serial out of the boundary-scan chain
//   TDO          out  1         serial data out
//   dr_capture   out  1         state is CAPTURE_DR
//   dr_shift     out  1         state is SHIFT_DR
//   dr_update    out  1         state is UPDATE_DR
//   bsr_select   out  1         instruction is EXTEST or SAMPLE/PRELOAD
//   mode         out  1         instruction is EXTEST
//   tlr_reset    out  1         state is TEST_LOGIC_RESET
//   ir_out       out  IR_WIDTH  current (updated) instruction

module jtag_tap_controller #(
    parameter int                     IR_WIDTH   = 4,
    parameter logic [31:0]            IDCODE_VAL = 32'h1ABC_D001,
    parameter logic [IR_WIDTH-1:0]    OP_EXTEST  = IR_WIDTH'(0),
    parameter logic [IR_WIDTH-1:0]    OP_SAMPLE  = IR_WIDTH'(2),
    parameter logic [IR_WIDTH-1:0]    OP_IDCODE  = IR_WIDTH'(1)
) (
    input  logic                TCK,
    input  logic                nTRST,
    input  logic                TMS,
    input  logic                TDI,
    input  logic                bsr_tdo,
    output logic                TDO,
    output logic                dr_capture,
    output logic                dr_shift,
    output logic                dr_update,
    output logic                bsr_select,
    output logic                mode,
    output logic                tlr_reset,
    output logic [IR_WIDTH-1:0] ir_out
);

    // Standard 1149.1 state codes, so a state dump reads like the datasheet.
    typedef enum logic [3:0] {
        TLR       = 4'hF,
        RTI       = 4'hC,
        SEL_DR    = 4'h7,
        CAP_DR    = 4'h6,
        SHIFT_DR  = 4'h2,
        EXIT1_DR  = 4'h1,
        PAUSE_DR  = 4'h3,
        EXIT2_DR  = 4'h0,
        UPDATE_DR = 4'h5,
        SEL_IR    = 4'h4,
        CAP_IR    = 4'hE,
        SHIFT_IR  = 4'hA,
        EXIT1_IR  = 4'h9,
        PAUSE_IR  = 4'hB,
        EXIT2_IR  = 4'h8,
        UPDATE_IR = 4'hD
    } tap_state_e;

    // Value loaded into the IR shifter on CAPTURE_IR: the mandatory 2'b01
    // in the two LSBs, zeros above.
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE_VAL = {{(IR_WIDTH-2){1'b0}}, 2'b01};

    tap_state_e          state_q;
    tap_state_e          state_d;
    logic [IR_WIDTH-1:0] ir_shift_q;
    logic [IR_WIDTH-1:0] ir_out_q;
    logic                bypass_q;
    logic [31:0]         idcode_q;

    // State-decoded strobes, registered from the next state so that they
    // line up exactly with the state register (no added latency).
    logic                tlr_q;
    logic                dr_capture_q;
    logic                dr_shift_q;
    logic                dr_update_q;
    logic                ir_shift_st_q;

    logic                sel_bsr;
    logic                sel_idcode;
    logic                sel_bypass;

    // Instruction decode; anything not explicitly defined falls back to BYPASS.
    always_comb begin
        sel_bsr    = (ir_out_q == OP_EXTEST) || (ir_out_q == OP_SAMPLE);
        sel_idcode = (ir_out_q == OP_IDCODE);
        sel_bypass = !sel_bsr && !sel_idcode;
    end

    // TMS-driven next-state function.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:       state_d = TMS ? TLR       : RTI;
            RTI:       state_d = TMS ? SEL_DR    : RTI;
            SEL_DR:    state_d = TMS ? SEL_IR    : CAP_DR;
            CAP_DR:    state_d = TMS ? EXIT1_DR  : SHIFT_DR;
            SHIFT_DR:  state_d = TMS ? EXIT1_DR  : SHIFT_DR;
            EXIT1_DR:  state_d = TMS ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:  state_d = TMS ? EXIT2_DR  : PAUSE_DR;
            EXIT2_DR:  state_d = TMS ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR: state_d = TMS ? SEL_DR    : RTI;
            SEL_IR:    state_d = TMS ? TLR       : CAP_IR;
            CAP_IR:    state_d = TMS ? EXIT1_IR  : SHIFT_IR;
            SHIFT_IR:  state_d = TMS ? EXIT1_IR  : SHIFT_IR;
            EXIT1_IR:  state_d = TMS ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:  state_d = TMS ? EXIT2_IR  : PAUSE_IR;
            EXIT2_IR:  state_d = TMS ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR: state_d = TMS ? SEL_DR    : RTI;
            default:   state_d = TLR;
        endcase
    end

    // State register, strobes and all scan registers. Register actions are
    // keyed on the state being left at this edge (capture on leaving
    // CAPTURE_x, shift on each edge spent in SHIFT_x, update on leaving
    // UPDATE_IR).
    always_ff @(posedge TCK) begin
        if (!nTRST) begin
            state_q       <= TLR;
            tlr_q         <= 1'b1;
            dr_capture_q  <= 1'b0;
            dr_shift_q    <= 1'b0;
            dr_update_q   <= 1'b0;
            ir_shift_st_q <= 1'b0;
            ir_shift_q    <= '0;
            ir_out_q      <= OP_IDCODE;
            bypass_q      <= 1'b0;
            idcode_q      <= '0;
        end else begin
            state_q       <= state_d;
            tlr_q         <= (state_d == TLR);
            dr_capture_q  <= (state_d == CAP_DR);
            dr_shift_q    <= (state_d == SHIFT_DR);
            dr_update_q   <= (state_d == UPDATE_DR);
            ir_shift_st_q <= (state_d == SHIFT_IR);

            case (state_q)
                CAP_IR:   ir_shift_q <= IR_CAPTURE_VAL;
                SHIFT_IR: ir_shift_q <= {TDI, ir_shift_q[IR_WIDTH-1:1]};
                default:  ir_shift_q <= ir_shift_q;
            endcase

            // Only the data register selected by the current instruction
            // moves; the other one holds its contents.
            if (state_q == CAP_DR) begin
                if (sel_bypass) begin
                    bypass_q <= 1'b0;
                end
                if (sel_idcode) begin
                    idcode_q <= IDCODE_VAL;
                end
            end else if (state_q == SHIFT_DR) begin
                if (sel_bypass) begin
                    bypass_q <= TDI;
                end
                if (sel_idcode) begin
                    idcode_q <= {TDI, idcode_q[31:1]};
                end
            end

            // Entering TLR by TMS wins; UPDATE_IR can never lead to TLR so
            // the two sources never collide.
            if (state_d == TLR) begin
                ir_out_q <= OP_IDCODE;
            end else if (state_q == UPDATE_IR) begin
                ir_out_q <= ir_shift_q;
            end
        end
    end

    // Serial output: combinational mux of registered shift bits; held low
    // outside the shift states.
    always_comb begin
        TDO = 1'b0;
        if (ir_shift_st_q) begin
            TDO = ir_shift_q[0];
        end else if (dr_shift_q) begin
            if (sel_bsr) begin
                TDO = bsr_tdo;
            end else if (sel_idcode) begin
                TDO = idcode_q[0];
            end else begin
                TDO = bypass_q;
            end
        end
    end

    assign dr_capture = dr_capture_q;
    assign dr_shift   = dr_shift_q;
    assign dr_update  = dr_update_q;
    assign tlr_reset  = tlr_q;
    assign ir_out     = ir_out_q;
    assign bsr_select = sel_bsr;
    assign mode       = (ir_out_q == OP_EXTEST);

endmodule

// File: tb/tb_jtag_tap_controller.sv
// tb/tb_jtag_tap_controller.sv - self-checking bench for jtag_tap_controller

module tb_jtag_tap_controller;

    logic       TCK = 1'b0;
    logic       nTRST;
    logic       TMS;
    logic       TDI;
    logic       bsr_tdo;
    logic       TDO;
    logic       dr_capture;
    logic       dr_shift;
    logic       dr_update;
    logic       bsr_select;
    logic       mode;
    logic       tlr_reset;
    logic [3:0] ir_out;

    always #5 TCK = ~TCK;

    jtag_tap_controller dut (
        .TCK        (TCK),
        .nTRST      (nTRST),
        .TMS        (TMS),
        .TDI        (TDI),
        .bsr_tdo    (bsr_tdo),
        .TDO        (TDO),
        .dr_capture (dr_capture),
        .dr_shift   (dr_shift),
        .dr_update  (dr_update),
        .bsr_select (bsr_select),
        .mode       (mode),
        .tlr_reset  (tlr_reset),
        .ir_out     (ir_out)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: states numbered 0..15 in datasheet walk order,
    // transitions from a table indexed [state][TMS].
    localparam int S_TLR = 0, S_CDR = 3, S_SHDR = 4, S_UDR = 8;
    localparam int S_CIR = 10, S_SHIR = 11, S_UIR = 15;
    localparam int NXT [16][2] = '{
        '{1, 0}, '{1, 2}, '{3, 9}, '{4, 5}, '{4, 5}, '{6, 8}, '{6, 7}, '{4, 8},
        '{1, 2}, '{10, 0}, '{11, 12}, '{11, 12}, '{13, 15}, '{13, 14}, '{11, 15}, '{1, 2}
    };

    int          ms;
    logic [3:0]  m_ir;
    logic [3:0]  m_irs;
    logic        m_byp;
    logic [31:0] m_id;
    bit          started = 0;

    function automatic bit m_is_bsr(input logic [3:0] ir);
        return (ir == 4'b0000) || (ir == 4'b0010);
    endfunction

    always @(posedge TCK) begin
        if (!nTRST) begin
            ms = S_TLR; m_ir = 4'b0001; m_irs = 4'b0; m_byp = 1'b0; m_id = 32'h0;
            started = 1;
        end else if (started) begin
            if (ms == S_CIR)  m_irs = 4'b0001;
            if (ms == S_SHIR) m_irs = {TDI, m_irs[3:1]};
            if (ms == S_UIR)  m_ir  = m_irs;
            if (ms == S_CDR) begin
                if (m_ir == 4'b0001) m_id = 32'h1ABC_D001;
                else if (!m_is_bsr(m_ir)) m_byp = 1'b0;
            end
            if (ms == S_SHDR) begin
                if (m_ir == 4'b0001) m_id = {TDI, m_id[31:1]};
                else if (!m_is_bsr(m_ir)) m_byp = TDI;
            end
            ms = NXT[ms][TMS];
            if (ms == S_TLR) m_ir = 4'b0001;
        end
    end

    // Compare process: every falling edge once the model has been reset.
    always @(negedge TCK) begin
        if (started) begin
            logic exp_tdo;
            exp_tdo = 1'b0;
            if (ms == S_SHIR) exp_tdo = m_irs[0];
            else if (ms == S_SHDR) begin
                if (m_is_bsr(m_ir)) exp_tdo = bsr_tdo;
                else if (m_ir == 4'b0001) exp_tdo = m_id[0];
                else exp_tdo = m_byp;
            end
            chk("m_tlr_reset",  tlr_reset,  ms == S_TLR);
            chk("m_dr_capture", dr_capture, ms == S_CDR);
            chk("m_dr_shift",   dr_shift,   ms == S_SHDR);
            chk("m_dr_update",  dr_update,  ms == S_UDR);
            chk("m_ir_out",     ir_out,     m_ir);
            chk("m_bsr_select", bsr_select, m_is_bsr(m_ir));
            chk("m_mode",       mode,       m_ir == 4'b0000);
            chk("m_tdo",        TDO,        exp_tdo);
        end
    end

    int cnt_cap, cnt_shift, cnt_upd;

    // One TCK cycle: inputs applied after the falling edge, TDO and strobes
    // sampled for the state that the next rising edge will leave.
    task automatic tick(input logic tms, input logic tdi, output logic tdo);
        @(negedge TCK);
        #1;
        TMS = tms; TDI = tdi; bsr_tdo = ~tdi;
        #1;
        tdo = TDO;
        if (dr_capture) cnt_cap++;
        if (dr_shift)   cnt_shift++;
        if (dr_update)  cnt_upd++;
    endtask

    task automatic settle();
        @(negedge TCK);
        #1;
    endtask

    // From RTI: full IR scan, ends back in RTI.
    task automatic ir_scan(input logic [3:0] v, output logic [3:0] bits);
        logic d;
        tick(1, 0, d); tick(1, 0, d); tick(0, 0, d); tick(0, 0, d);
        for (int i = 0; i < 4; i++) begin
            tick(i == 3, v[i], d);
            bits[i] = d;
        end
        tick(1, 0, d); tick(0, 0, d);
        settle();
    endtask

    // From RTI: DR scan of n bits, optional 3-cycle PAUSE_DR after pause_at bits.
    task automatic dr_scan(input int n, input logic [63:0] tdi, input int pause_at,
                           output logic [63:0] bits);
        logic d;
        bits = '0;
        tick(1, 0, d); tick(0, 0, d); tick(0, 0, d);
        for (int i = 0; i < n; i++) begin
            tick((i == n - 1) || (i == pause_at - 1), tdi[i], d);
            bits[i] = d;
            if (i == pause_at - 1 && i != n - 1) begin
                tick(0, 0, d);
                tick(0, 0, d); tick(0, 0, d); tick(1, 0, d);
                tick(0, 0, d);
            end
        end
        tick(1, 0, d); tick(0, 0, d);
        settle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

    initial begin
        logic [3:0]  b4;
        logic [63:0] b;
        logic        d;

        nTRST = 1'b0; TMS = 1'b1; TDI = 1'b0; bsr_tdo = 1'b0;
        @(posedge TCK);
        settle();
        chk("rst_tlr_reset", tlr_reset, 1'b1);
        chk("rst_ir_out", ir_out, 4'b0001);
        chk("rst_tdo", TDO, 1'b0);
        chk("rst_dr_shift", dr_shift, 1'b0);
        chk("rst_bsr_select", bsr_select, 1'b0);
        chk("rst_mode", mode, 1'b0);
        nTRST = 1'b1; TMS = 1'b0;
        settle();
        chk("rti_tlr_reset", tlr_reset, 1'b0);
        chk("rti_ir_out", ir_out, 4'b0001);

        dr_scan(32, 64'h0, -1, b);
        chk("idcode_read", b[31:0], 32'h1ABC_D001);

        cnt_cap = 0; cnt_upd = 0;
        dr_scan(32, 64'hFFFF_FFFF, 8, b);
        chk("idcode_pause_read", b[31:0], 32'h1ABC_D001);
        chk("idcode_capture_cnt", cnt_cap, 1);
        chk("idcode_update_cnt", cnt_upd, 1);

        ir_scan(4'b0000, b4);
        chk("ir_capture_bits", b4[1:0], 2'b01);
        chk("extest_ir_out", ir_out, 4'b0000);
        chk("extest_bsr_select", bsr_select, 1'b1);
        chk("extest_mode", mode, 1'b1);

        ir_scan(4'b1111, b4);
        chk("ir_capture_word", b4, 4'b0001);
        chk("bypass_ir_out", ir_out, 4'b1111);
        chk("bypass_bsr_select", bsr_select, 1'b0);
        cnt_shift = 0;
        dr_scan(5, 64'b01101, -1, b);
        chk("bypass_tdo", b[4:0], 5'b11010);
        chk("bypass_shift_cnt", cnt_shift, 5);

        ir_scan(4'b0101, b4);
        dr_scan(4, 64'b0110, -1, b);
        chk("undef_bypass_tdo", b[3:0], 4'b1100);

        ir_scan(4'b0010, b4);
        chk("sample_bsr_select", bsr_select, 1'b1);
        chk("sample_mode", mode, 1'b0);
        cnt_cap = 0; cnt_upd = 0;
        dr_scan(8, 64'hA5, 4, b);
        chk("sample_bsr_tdo", b[7:0], 8'h5A);
        chk("sample_capture_cnt", cnt_cap, 1);
        chk("sample_update_cnt", cnt_upd, 1);

        ir_scan(4'b0000, b4);
        tick(1, 0, d); tick(0, 0, d); tick(0, 0, d); tick(1, 0, d); tick(0, 0, d);
        settle();
        chk("pause_ir_held", ir_out, 4'b0000);
        for (int i = 0; i < 5; i++) tick(1, 0, d);
        settle();
        chk("tms5_tlr_reset", tlr_reset, 1'b1);
        chk("tms5_ir_out", ir_out, 4'b0001);
        tick(0, 0, d);

        ir_scan(4'b1111, b4);
        cnt_upd = 0;
        tick(1, 0, d); tick(0, 0, d); tick(0, 0, d);
        tick(0, 1, d); tick(0, 0, d);
        @(negedge TCK);
        #1;
        nTRST = 1'b0;
        settle();
        chk("trst_tlr_reset", tlr_reset, 1'b1);
        chk("trst_dr_shift", dr_shift, 1'b0);
        chk("trst_ir_out", ir_out, 4'b0001);
        nTRST = 1'b1;
        tick(0, 0, d); tick(0, 0, d);
        chk("trst_no_update", cnt_upd, 0);

        settle();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
